// File: rtl/dir_debounce.sv
// Four independent direction debouncers: raw switches are captured, then each bit
// must disagree with its debounced value for DEBOUNCE_TICKS ce ticks before it updates.
// Optional macro DIR_DEBOUNCE_SYNC_EN turns the capture stage into a two-flop synchronizer.
module dir_debounce #(
    parameter int unsigned DEBOUNCE_TICKS = 8,
    parameter int unsigned CNT_W          = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic [3:0] dirinput,
    output logic [3:0] diroutput,
    output logic [3:0] changed
);

    localparam int unsigned       NDIR     = 4;
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_TICKS - 1);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } st_e;

    logic [3:0] x_q;

`ifdef DIR_DEBOUNCE_SYNC_EN
    // dirinput is asynchronous; meta_q absorbs metastability before x_q is used
    logic [3:0] meta_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            x_q    <= '0;
        end else begin
            meta_q <= dirinput;
            x_q    <= meta_q;
        end
    end
`else
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_q <= '0;
        end else begin
            x_q <= dirinput;
        end
    end
`endif

    st_e              st_q  [NDIR];
    st_e              st_d  [NDIR];
    logic [CNT_W-1:0] cnt_q [NDIR];
    logic [CNT_W-1:0] cnt_d [NDIR];
    logic [3:0]       out_q;
    logic [3:0]       out_d;
    logic [3:0]       chg_q;
    logic [3:0]       chg_d;

    // A reverting input is checked before the terminal count, so a glitch always wins
    always_comb begin
        out_d = out_q;
        chg_d = '0;
        for (int i = 0; i < NDIR; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = cnt_q[i];
            case (st_q[i])
                ST_STABLE: begin
                    cnt_d[i] = '0;
                    if (x_q[i] != out_q[i]) begin
                        st_d[i] = ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (x_q[i] == out_q[i]) begin
                        st_d[i]  = ST_STABLE;
                        cnt_d[i] = '0;
                    end else if (ce) begin
                        if (cnt_q[i] == CNT_TERM) begin
                            out_d[i] = x_q[i];
                            chg_d[i] = 1'b1;
                            cnt_d[i] = '0;
                            st_d[i]  = ST_STABLE;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    st_d[i]  = ST_STABLE;
                    cnt_d[i] = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_q <= '0;
            chg_q <= '0;
            for (int i = 0; i < NDIR; i++) begin
                st_q[i]  <= ST_STABLE;
                cnt_q[i] <= '0;
            end
        end else begin
            out_q <= out_d;
            chg_q <= chg_d;
            for (int i = 0; i < NDIR; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign diroutput = out_q;
    assign changed   = chg_q;

endmodule
